// File: rtl/switch_debounce_toggle_if.sv
// Button-conditioning bus: raw button inputs in; debounced level, press strobe
// and press-toggled bit out. The conditioner uses the slave modport and the
// button source uses the master modport.
interface switch_debounce_toggle_if #(
  parameter int N = 1
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] toggle_q;

  modport master (output btn_raw, input btn_level, press_pulse, toggle_q);
  modport slave  (input btn_raw, output btn_level, press_pulse, toggle_q);
endinterface

// File: rtl/switch_debounce_toggle.sv
// switch_debounce_toggle: N-channel pushbutton synchroniser and debouncer.
// Each channel produces a clean level, a one-cycle press strobe and a bit
// that toggles on every accepted press.
// Build option: define INPUT_SYNC_EN to use a 2-flop synchroniser on btn_raw.
// Without it, the input passes through a single input register.
// The debounce FSM is the same in both builds. Only the latency moves by one cycle.

// One debounce channel: a 4-state FSM and a qualification counter.
module sdt_channel #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic s_i,
  output logic level_o,
  output logic pulse_o,
  output logic toggle_o
);
  typedef enum logic [1:0] {STABLE_LO, RISE_CHK, STABLE_HI, FALL_CHK} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             tog_q, tog_d;

  // State, counter and registered outputs. Reset discards any partial window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      tog_q   <= tog_d;
    end
  end

  // Next state. Any bounce during a check window returns to the stable state
  // with the counter at zero, so qualification always restarts from scratch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    tog_d   = tog_q;
    case (state_q)
      STABLE_LO: begin
        if (s_i) begin
          state_d = RISE_CHK;
          cnt_d   = ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      RISE_CHK: begin
        if (!s_i) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
          tog_d   = ~tog_q;
        end else begin
          cnt_d   = cnt_q + ONE;
        end
      end
      STABLE_HI: begin
        if (!s_i) begin
          state_d = FALL_CHK;
          cnt_d   = ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      FALL_CHK: begin
        if (s_i) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o  = level_q;
  assign pulse_o  = pulse_q;
  assign toggle_o = tog_q;
endmodule

module switch_debounce_toggle #(
  parameter int N               = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  switch_debounce_toggle_if.slave  btn_if
);
  logic [N-1:0] sync_q;
  logic [N-1:0] level_w, pulse_w, tog_w;

`ifdef INPUT_SYNC_EN
  logic [N-1:0] meta_q;

  // Two-flop synchroniser for truly asynchronous buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_if.btn_raw;
      sync_q <= meta_q;
    end
  end
`else
  // Single input register for sources that are already synchronous.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= btn_if.btn_raw;
  end
`endif

  for (genvar g = 0; g < N; g++) begin : g_ch
    sdt_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .s_i      (sync_q[g]),
      .level_o  (level_w[g]),
      .pulse_o  (pulse_w[g]),
      .toggle_o (tog_w[g])
    );
  end

  assign btn_if.btn_level   = level_w;
  assign btn_if.press_pulse = pulse_w;
  assign btn_if.toggle_q    = tog_w;
endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Scoreboard bench for switch_debounce_toggle (N=2, DEBOUNCE_CYCLES=4).
// Stimulus pushes the expected output event, with its edge number, for each
// button change. The monitor pops and compares an expected event whenever a
// press pulse occurs or btn_level changes.
module tb_switch_debounce_toggle;
`ifdef INPUT_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int D = 4;
  localparam int L = S + D - 1;   // edges from the sampled raw change to the output update
  localparam int R = 87 + S;      // reset lands while channel 0 is in RISE_CHK with cnt=2

  typedef struct {
    int         cyc;
    logic [1:0] lvl;
    logic [1:0] pls;
    logic [1:0] tog;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [1:0] prev_lvl = 2'b00;

  switch_debounce_toggle_if #(.N(2)) bif();

  switch_debounce_toggle #(.N(2), .DEBOUNCE_CYCLES(D), .CNT_W(3)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .btn_if (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic wait_neg(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // The raw change is applied after edge e-1, so edge e is the first to sample it.
  task automatic drive_at(input int e, input logic [1:0] v);
    wait_neg(e - 1);
    bif.btn_raw = v;
  endtask

  task automatic push(input int c, input logic [1:0] l, input logic [1:0] p, input logic [1:0] t);
    ev_t ev;
    ev.cyc = c; ev.lvl = l; ev.pls = p; ev.tog = t;
    exp_q.push_back(ev);
  endtask

  task automatic chk_all0(input string name);
    chk({name, "_lvl"}, bif.btn_level, 2'b00);
    chk({name, "_pls"}, bif.press_pulse, 2'b00);
    chk({name, "_tog"}, bif.toggle_q, 2'b00);
  endtask

  // Monitor: an output event is a press pulse or a change of btn_level.
  always @(negedge clk) begin
    if ((bif.press_pulse != 2'b00) || (bif.btn_level != prev_lvl)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event @edge %0d: lvl=%b pls=%b tog=%b none expected",
                 cyc, bif.btn_level, bif.press_pulse, bif.toggle_q);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL ev_edge: got %0d expected %0d", cyc, e.cyc);
        end
        chk("ev_level", bif.btn_level, e.lvl);
        chk("ev_pulse", bif.press_pulse, e.pls);
        chk("ev_toggle", bif.toggle_q, e.tog);
      end
    end
    prev_lvl = bif.btn_level;
  end

  initial begin
    reset = 1'b1;
    bif.btn_raw = 2'b11;
    // 1: reset held for edges 1..3 with buttons pressed; outputs stay 0.
    for (int e = 1; e <= 3; e++) begin
      wait_neg(e);
      chk_all0("reset");
    end
    reset = 1'b0;
    bif.btn_raw = 2'b00;
    wait_neg(4);
    chk_all0("post_reset");

    // 2: press ch0 at edge 10.
    drive_at(10, 2'b01); push(10 + L, 2'b01, 2'b01, 2'b01);
    wait_neg(10 + L + 1);
    chk("pulse_one_cycle", bif.press_pulse, 2'b00);
    // Release: level drops, no pulse, toggle unchanged.
    drive_at(20, 2'b00); push(20 + L, 2'b00, 2'b00, 2'b01);

    // 3: glitch held for 3 samples only, so it is rejected.
    drive_at(30, 2'b01);
    drive_at(33, 2'b00);
    wait_neg(40);
    chk("glitch_level", bif.btn_level, 2'b00);
    chk("glitch_toggle", bif.toggle_q, 2'b01);

    // 4: second press toggles ch0 back to 0.
    drive_at(45, 2'b01); push(45 + L, 2'b01, 2'b01, 2'b00);
    drive_at(55, 2'b00); push(55 + L, 2'b00, 2'b00, 2'b00);

    // 5: simultaneous press on both channels.
    drive_at(65, 2'b11); push(65 + L, 2'b11, 2'b11, 2'b11);
    wait_neg(65 + L);
    chk("xor_out", {1'b0, bif.toggle_q[0] ^ bif.toggle_q[1]}, 2'b00);
    drive_at(75, 2'b00); push(75 + L, 2'b00, 2'b00, 2'b11);

    // 6: reset during RISE_CHK (cnt=2). The full window is needed again afterwards.
    drive_at(85, 2'b01);
    wait_neg(R - 1);
    reset = 1'b1;
    wait_neg(R);
    chk_all0("mid_reset");
    wait_neg(R + 1);
    reset = 1'b0;
    push(R + 2 + L, 2'b01, 2'b01, 2'b01);

    // Bounce on ch1: restart from the last rising edge (108).
    drive_at(105, 2'b11);
    drive_at(107, 2'b01);
    drive_at(108, 2'b11); push(108 + L, 2'b11, 2'b10, 2'b11);
    drive_at(120, 2'b00); push(120 + L, 2'b00, 2'b00, 2'b11);

    wait_neg(140);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
